ddr4_dram_responder: RTL
========================

# ddr4_dram_responder

Device-side responder for the DDR4 command bus driven by the controller FSM. Decodes commands on each CK_t edge and tracks per-bank open and closed state. Enforces a reduced set of DDR4 timing rules, stores write bursts in an internal array and returns read bursts after CAS latency. It is the simulation and FPGA stand-in for the DRAM and flags every protocol violation the controller commits.

## Interface
Parameters:
- ROW_W, 4: row address bits used (≤10).
- COL_W, 4: column address bits used (≥3); bursts are 4-aligned.
- DQ_W, 8: data width.
- CL, 5: read latency in cycles.
- CWL, 4: write latency in cycles.
- TRCD, 3: cycles from ACT to first RD/WR allowed on the same bank.
- TRP, 3: cycles from PRE to next ACT/REF allowed on the same bank.
- TRFC, 8: busy cycles after REF.
- TMOD, 4: busy cycles after MRS.
- TXPR, 5: busy cycles after reset release.
- TCCD, 4: minimum spacing between any RD/WR commands.

Ports:
- CK_t, in, 1: clock; all logic on the rising edge.
- RESET_n, in, 1: reset; asynchronous, active-low.
- cs_n, act_n, ras_n, cas_n, we_n, in, 1 each: command pins.
- ba, in, 2: bank address (4 banks).
- addr, in, 14: address; addr[10] is the all-banks flag for PRE.
- dq_in, in, DQ_W: write data.
- dq_out, out, DQ_W: read data.
- dq_oe, out, 1: dq_out valid.
- ready, out, 1: init done and not in tRFC/tMOD.
- bank_open, out, 4: per-bank row-open flags.
- err, out, 1: sticky violation flag.
- err_code, out, 3: code of the most recent violation.

## Operation
- Reset values: all outputs 0; bank timers, bursts in flight and busy counters cleared. Array contents are not reset.
- Asserting RESET_n low mid-burst drops the burst and deasserts dq_oe asynchronously.
- Command decode when cs_n=0:
  - act_n=0: ACT.
  - Otherwise {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 100 WR, 101 RD, 111 NOP.
  - Codes 011 and 110 are reserved.
  - cs_n=1 is NOP.
- Busy state:
  - After reset release the device is busy for TXPR cycles, then ready=1.
  - MRS sets busy for TMOD cycles; REF sets busy for TRFC cycles.
  - While busy, any non-NOP command is code 1.
- ACT: the bank must be closed and its tRP timer expired, else code 2. Latches row=addr[ROW_W-1:0], sets bank_open and starts the tRCD timer.
- RD/WR: the bank must be open and its tRCD timer expired, else code 3. Fewer than TCCD cycles since the previous accepted RD/WR is code 4.
  - Column base = addr[COL_W-1:2]; the 4 beats use col base*4+0..3 in order.
- PRE:
  - Closes ba; with addr[10]=1 it closes all banks.
  - PRE to a closed bank is a legal no-op.
  - Each bank closed by this command starts its tRP timer.
- REF or MRS with any bank open or any tRP timer running is code 5.
- Reserved command is code 6.
- Any violating command is ignored. It sets err=1 and err_code; only reset clears them.
- RD and WR tokens travel through a delay pipeline of depth max(CL,CWL)+4, so concurrent in-flight bursts are supported.

## Timing
- Cycle N means the Nth rising edge after the edge that sampled the command.
- RD at cycle 0: dq_out is registered and dq_oe=1 on cycles CL..CL+3 with beats 0..3.
- WR at cycle 0: dq_in is sampled on cycles CWL..CWL+3 as beats 0..3.
- A write beat and a read beat to the same location on the same edge: the read returns the pre-write value.
- ACT at cycle 0: RD/WR is legal from cycle TRCD.
- PRE at cycle 0: ACT/REF is legal from cycle TRP.
- ready behaviour:
  - After MRS or REF accepted at cycle 0, ready=0 on cycles 1..T (T = TMOD or TRFC) and returns to 1 at cycle T+1.
  - After reset release, ready rises TXPR cycles later.
- Bursts already in flight complete even if PRE or REF is issued afterwards.
- Read and write bursts may overlap in time; dq_in and dq_out are independent.

## Test plan
- Release RESET_n and send NOPs → ready=0 for 5 cycles, then 1; err=0.
- ACT ba=1 row 3 at t; WR col 4 at t+3 with dq_in 0xA0..0xA3 on t+7..t+10; RD col 4 at t+11 → dq_oe=1 on t+16..t+19 with 0xA0..0xA3.
- RD 2 cycles after ACT → err=1, err_code=3, dq_oe stays 0. ACT to an open bank → err_code=2.
- RD at t and RD at t+2 → second RD rejected with err_code=4; only one 4-beat burst is returned.
- Close all banks with PRE addr[10]=1; REF 3 cycles later → ready=0 for 8 cycles. An ACT during that window → err_code=1.
- Pull RESET_n low while dq_oe=1 → dq_oe=0 and bank_open=0 at once. Re-init, then read the earlier location → previous data is returned.

Source files
------------

// File: rtl/ddr4_dram_responder.sv
// rtl/ddr4_dram_responder.sv - DDR4 device-side responder: command decode, bank timing checks, burst storage and readback
`timescale 1ns/1ps
module ddr4_dram_responder #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    parameter int DQ_W  = 8,
    parameter int CL    = 5,
    parameter int CWL   = 4,
    parameter int TRCD  = 3,
    parameter int TRP   = 3,
    parameter int TRFC  = 8,
    parameter int TMOD  = 4,
    parameter int TXPR  = 5,
    parameter int TCCD  = 4
) (
    input  logic            CK_t,
    input  logic            RESET_n,
    input  logic            cs_n,
    input  logic            act_n,
    input  logic            ras_n,
    input  logic            cas_n,
    input  logic            we_n,
    input  logic [1:0]      ba,
    input  logic [13:0]     addr,
    input  logic [DQ_W-1:0] dq_in,
    output logic [DQ_W-1:0] dq_out,
    output logic            dq_oe,
    output logic            ready,
    output logic [3:0]      bank_open,
    output logic            err,
    output logic [2:0]      err_code
);

    localparam int LAT_MAX = (CL > CWL) ? CL : CWL;
    localparam int DEPTH   = LAT_MAX + 4;
    localparam int CB_W    = COL_W - 2;
    localparam int MEM_AW  = 2 + ROW_W + COL_W;
    localparam int MEM_D   = 1 << MEM_AW;
    localparam int TIM_W   = 8;

    typedef enum logic [2:0] {
        CMD_NOP, CMD_ACT, CMD_MRS, CMD_REF, CMD_PRE, CMD_WR, CMD_RD, CMD_RSV
    } cmd_e;

    typedef struct packed {
        logic             valid;
        logic             is_wr;
        logic [1:0]       bank;
        logic [ROW_W-1:0] row;
        logic [CB_W-1:0]  cb;
    } tok_t;

    logic [TIM_W-1:0]  r_busy_cnt;
    logic [TIM_W-1:0]  r_ccd_cnt;
    logic [TIM_W-1:0]  r_trcd_cnt [4];
    logic [TIM_W-1:0]  r_trp_cnt  [4];
    logic [ROW_W-1:0]  r_row      [4];
    logic [3:0]        r_bank_open;
    logic              r_err;
    logic [2:0]        r_err_code;
    logic [DQ_W-1:0]   r_dq_out;
    logic              r_dq_oe;
    tok_t              r_pipe     [DEPTH];
    logic [DQ_W-1:0]   r_mem      [MEM_D];

    cmd_e              w_cmd;
    logic [2:0]        w_code;
    logic              w_accept;
    logic              w_trp_any;
    logic              w_rd_hit;
    logic              w_wr_hit;
    logic [MEM_AW-1:0] w_rd_addr;
    logic [MEM_AW-1:0] w_wr_addr;

    always_comb begin
        w_cmd = CMD_NOP;
        if (!cs_n) begin
            if (!act_n) begin
                w_cmd = CMD_ACT;
            end else begin
                case ({ras_n, cas_n, we_n})
                    3'b000:  w_cmd = CMD_MRS;
                    3'b001:  w_cmd = CMD_REF;
                    3'b010:  w_cmd = CMD_PRE;
                    3'b100:  w_cmd = CMD_WR;
                    3'b101:  w_cmd = CMD_RD;
                    3'b111:  w_cmd = CMD_NOP;
                    default: w_cmd = CMD_RSV;
                endcase
            end
        end
    end

    always_comb begin
        w_trp_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_trp_cnt[i] != '0) w_trp_any = 1'b1;
        end
    end

    // Busy outranks every other violation; 0 means the command is legal.
    always_comb begin
        w_code = 3'd0;
        if (w_cmd != CMD_NOP) begin
            if (r_busy_cnt != '0) begin
                w_code = 3'd1;
            end else begin
                case (w_cmd)
                    CMD_ACT: if (r_bank_open[ba] || r_trp_cnt[ba] != '0) w_code = 3'd2;
                    CMD_RD, CMD_WR: begin
                        if (!r_bank_open[ba] || r_trcd_cnt[ba] != '0) w_code = 3'd3;
                        else if (r_ccd_cnt != '0)                     w_code = 3'd4;
                    end
                    CMD_REF, CMD_MRS: if (|r_bank_open || w_trp_any) w_code = 3'd5;
                    CMD_RSV: w_code = 3'd6;
                    default: w_code = 3'd0;
                endcase
            end
        end
    end

    assign w_accept = (w_cmd != CMD_NOP) && (w_code == 3'd0);

    // Tokens advance one stage per edge; beat b of a burst is serviced from stage LAT-1+b.
    always_comb begin
        w_rd_hit  = 1'b0;
        w_wr_hit  = 1'b0;
        w_rd_addr = '0;
        w_wr_addr = '0;
        for (int b = 0; b < 4; b++) begin
            if (r_pipe[CL-1+b].valid && !r_pipe[CL-1+b].is_wr) begin
                w_rd_hit  = 1'b1;
                w_rd_addr = {r_pipe[CL-1+b].bank, r_pipe[CL-1+b].row, r_pipe[CL-1+b].cb, 2'(b)};
            end
            if (r_pipe[CWL-1+b].valid && r_pipe[CWL-1+b].is_wr) begin
                w_wr_hit  = 1'b1;
                w_wr_addr = {r_pipe[CWL-1+b].bank, r_pipe[CWL-1+b].row, r_pipe[CWL-1+b].cb, 2'(b)};
            end
        end
    end

    always_ff @(posedge CK_t or negedge RESET_n) begin
        if (!RESET_n) begin
            r_busy_cnt  <= TIM_W'(TXPR);
            r_ccd_cnt   <= '0;
            r_bank_open <= '0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_trcd_cnt[i] <= '0;
                r_trp_cnt[i]  <= '0;
                r_row[i]      <= '0;
            end
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - 1'b1;
            if (r_ccd_cnt != '0)  r_ccd_cnt  <= r_ccd_cnt - 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (r_trcd_cnt[i] != '0) r_trcd_cnt[i] <= r_trcd_cnt[i] - 1'b1;
                if (r_trp_cnt[i] != '0)  r_trp_cnt[i]  <= r_trp_cnt[i] - 1'b1;
            end
            r_pipe[0] <= '0;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];

            if (w_code != 3'd0) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end

            // Timers load LAT-1 so the command is legal on the edge where they read zero.
            if (w_accept) begin
                case (w_cmd)
                    CMD_ACT: begin
                        r_bank_open[ba] <= 1'b1;
                        r_row[ba]       <= addr[ROW_W-1:0];
                        r_trcd_cnt[ba]  <= TIM_W'(TRCD - 1);
                    end
                    CMD_PRE: begin
                        for (int i = 0; i < 4; i++) begin
                            if ((addr[10] || ba == 2'(i)) && r_bank_open[i]) begin
                                r_bank_open[i] <= 1'b0;
                                r_trp_cnt[i]   <= TIM_W'(TRP - 1);
                            end
                        end
                    end
                    CMD_MRS: r_busy_cnt <= TIM_W'(TMOD + 1);
                    CMD_REF: r_busy_cnt <= TIM_W'(TRFC + 1);
                    CMD_RD, CMD_WR: begin
                        r_pipe[0] <= '{valid: 1'b1, is_wr: (w_cmd == CMD_WR), bank: ba,
                                       row: r_row[ba], cb: addr[COL_W-1:2]};
                        r_ccd_cnt <= TIM_W'(TCCD - 1);
                    end
                    default: ;
                endcase
            end

            r_dq_oe  <= w_rd_hit;
            r_dq_out <= w_rd_hit ? r_mem[w_rd_addr] : '0;
        end
    end

    // Array is deliberately left unreset so contents survive RESET_n.
    always_ff @(posedge CK_t) begin
        if (w_wr_hit) r_mem[w_wr_addr] <= dq_in;
    end

    assign dq_out    = r_dq_out;
    assign dq_oe     = r_dq_oe;
    assign ready     = (r_busy_cnt == '0);
    assign bank_open = r_bank_open;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
